// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W = 4;

  // Group-level generate/propagate pair fed to the second-level lookahead.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of pipeline stages (and the latency) for a given configuration.
  function automatic int calc_stages(input int width, input int grp_per_stage);
    return width / (GROUP_W * grp_per_stage);
  endfunction

endpackage

// File: rtl/cla_4b_gp.sv
// Combinational 4-bit carry-lookahead group: sum bits plus group G/P.
module cla_4b_gp
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               g,
  output logic               p
);

  logic [GROUP_W-1:0] gb;
  logic [GROUP_W-1:0] pb;
  logic [GROUP_W-1:0] c;

  assign gb = a & b;
  assign pb = a ^ b;

  // Flattened lookahead carries into each bit of the group.
  assign c[0] = cin;
  assign c[1] = gb[0] | (pb[0] & cin);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & cin);

  assign s = pb ^ c;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);
  assign p = &pb;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves
// GRP_PER_STAGE 4-bit groups and registers the inter-stage carry; the
// finished sum bits overwrite the consumed operand-A bits in place.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int GRP_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, GRP_PER_STAGE);
  localparam int NGRP   = WIDTH / GROUP_W;
  localparam int SW     = GROUP_W * GRP_PER_STAGE;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64 || GRP_PER_STAGE < 1
      || (NGRP % GRP_PER_STAGE) != 0) begin : g_bad_param
    $fatal(1, "cla_pipe_adder: illegal WIDTH/GRP_PER_STAGE combination");
  end

  // Carry out of the first n groups of a stage, in sum-of-products form.
  function automatic logic la_carry(input gp_t [GRP_PER_STAGE-1:0] grp,
                                    input logic cin, input int n);
    logic c;
    logic pp;
    c  = 1'b0;
    pp = 1'b1;
    for (int i = GRP_PER_STAGE - 1; i >= 0; i--) begin
      if (i < n) begin
        c  = c | (grp[i].g & pp);
        pp = pp & grp[i].p;
      end
    end
    return c | (pp & cin);
  endfunction

  // Overflow: carry into the MSB (recovered from a^b^s) XOR carry out.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb,
                                  input logic s_msb, input logic cout);
    return (a_msb ^ b_msb ^ s_msb) ^ cout;
  endfunction

  logic                    en;
  logic [STAGES-1:0]       vld_p;
  logic [WIDTH-1:0]        w_p   [STAGES];
  logic [WIDTH-1:0]        b_p   [STAGES];
  logic [STAGES-1:0]       cy_p;
  logic [WIDTH-1:0]        s_all;
  gp_t  [NGRP-1:0]         gp;
  logic [NGRP-1:0]         gcin;
  logic [STAGES-1:0]       scout;
  logic [WIDTH-1:0]        stg_res [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int K = g / GRP_PER_STAGE;
    cla_4b_gp u_grp (
      .a   (w_p[K][g*GROUP_W +: GROUP_W]),
      .b   (b_p[K][g*GROUP_W +: GROUP_W]),
      .cin (gcin[g]),
      .s   (s_all[g*GROUP_W +: GROUP_W]),
      .g   (gp[g].g),
      .p   (gp[g].p)
    );
  end

  // Second-level lookahead: group carry-ins and stage carry-out per stage.
  always_comb begin
    gcin  = '0;
    scout = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j < GRP_PER_STAGE; j++) begin
        gcin[k*GRP_PER_STAGE + j] =
          la_carry(gp[k*GRP_PER_STAGE +: GRP_PER_STAGE], cy_p[k], j);
      end
      scout[k] = la_carry(gp[k*GRP_PER_STAGE +: GRP_PER_STAGE], cy_p[k],
                          GRP_PER_STAGE);
    end
  end

  // Merge each stage's freshly computed sum bits into its working word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_res[k]             = w_p[k];
      stg_res[k][k*SW +: SW] = s_all[k*SW +: SW];
    end
  end

  // ---- stage boundary: control and output registers (reset) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      out_valid <= vld_p[STAGES-1];
      sum       <= stg_res[STAGES-1];
      c_out     <= scout[STAGES-1];
      ovf       <= ovf_of(w_p[STAGES-1][WIDTH-1], b_p[STAGES-1][WIDTH-1],
                          s_all[WIDTH-1], scout[STAGES-1]);
    end
  end

  // ---- stage boundary: operand/partial-sum registers (no reset) ----
  always_ff @(posedge clk) begin
    if (en) begin
      w_p[0]  <= a;
      b_p[0]  <= sub ? ~b : b;
      cy_p[0] <= sub | c_in;
      for (int k = 1; k < STAGES; k++) begin
        w_p[k]  <= stg_res[k-1];
        b_p[k]  <= b_p[k-1];
        cy_p[k] <= scout[k-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: 16-bit/2-group instance and 4-bit/1-group instance.
module tb_cla_pipe_adder;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  localparam int STG16 = 2;
  localparam int STG4  = 1;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic        c_in16, sub16, c_out16, ovf16;
  logic [15:0] a16, b16, sum16;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic        c_in4, sub4, c_out4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int   nchk  = 0;
  int   npass = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b1;
  exp_t q16[$];
  exp_t q4[$];
  int   pop_cyc16[$];

  vec_t tbl [8] = '{
    '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0}
  };

  cla_pipe_adder #(.WIDTH(16), .GRP_PER_STAGE(2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .c_in(c_in16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .c_out(c_out16), .ovf(ovf16)
  );

  cla_pipe_adder #(.WIDTH(4), .GRP_PER_STAGE(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Independent 4-bit reference: {ovf, c_out, sum}.
  function automatic logic [5:0] ref4(input logic [3:0] av, input logic [3:0] bv,
                                      input logic ci, input logic sb);
    logic [3:0] bb;
    logic [4:0] t;
    logic       ov;
    bb = sb ? ~bv : bv;
    t  = {1'b0, av} + {1'b0, bb} + {4'b0, (sb ? 1'b1 : ci)};
    ov = (av[3] == bb[3]) && (t[3] != av[3]);
    return {ov, t[4], t[3:0]};
  endfunction

  // Present one beat and hold it until accepted; push the expectation.
  task automatic send(input bit d4, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb, input logic [15:0] es,
                      input logic eco, input logic eov);
    exp_t e;
    int   tries;
    bit   done;
    tries = 0;
    done  = 1'b0;
    @(posedge clk); #1;
    if (d4) begin
      in_valid4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; c_in4 = ci; sub4 = sb;
    end else begin
      in_valid16 = 1'b1; a16 = av; b16 = bv; c_in16 = ci; sub16 = sb;
    end
    while (!done) begin
      @(negedge clk);
      if (d4 ? in_ready4 : in_ready16) begin
        e.s = es; e.co = eco; e.ov = eov; e.acc = cyc + 1; e.lat = chk_lat;
        if (d4) q4.push_back(e);
        else    q16.push_back(e);
        done = 1'b1;
      end else if (++tries > 100) begin
        nchk++;
        $display("FAIL accept_timeout: in_ready stuck 0 want 1");
        done = 1'b1;
      end
    end
  endtask

  task automatic send_vec(input vec_t v);
    send(1'b0, v.a, v.b, v.ci, v.sb, v.s, v.co, v.ov);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    in_valid4  = 1'b0;
  endtask

  task automatic drain(input bit d4);
    int n;
    n = 0;
    while ((d4 ? q4.size() : q16.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(d4 ? "drain4_pending" : "drain16_pending", d4 ? q4.size() : q16.size(), 0);
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid16 && out_ready16) begin
      if (q16.size() == 0) begin
        nchk++;
        $display("FAIL unexpected16: got sum %0h want no output", sum16);
      end else begin
        e = q16.pop_front();
        chk("sum16", sum16, e.s);
        chk("c_out16", c_out16, e.co);
        chk("ovf16", ovf16, e.ov);
        if (e.lat) chk("latency16", cyc - e.acc, STG16);
        pop_cyc16.push_back(cyc);
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        nchk++;
        $display("FAIL unexpected4: got sum %0h want no output", sum4);
      end else begin
        e = q4.pop_front();
        chk("sum4", sum4, e.s);
        chk("c_out4", c_out4, e.co);
        chk("ovf4", ovf4, e.ov);
        if (e.lat) chk("latency4", cyc - e.acc, STG4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hs;
    logic        hco, hov;
    logic [5:0]  r;
    int          consec, n;
    bit          saw;

    rst = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; c_in16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
    in_valid4  = 1'b0; a4  = '0; b4  = '0; c_in4  = 1'b0; sub4  = 1'b0; out_ready4  = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid16", out_valid16, 0);
    chk("rst_sum16", sum16, 0);
    chk("rst_c_out16", c_out16, 0);
    chk("rst_ovf16", ovf16, 0);
    chk("rst_out_valid4", out_valid4, 0);
    chk("rst_sum4", sum4, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready16_after_rst", in_ready16, 1);
    chk("in_ready4_after_rst", in_ready4, 1);

    // Carry ripple through every group, then subtract/overflow corners.
    send(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(1'b0, 16'h0005, 16'h000A, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0);
    send(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    idle();
    drain(1'b0);

    // Eight back-to-back beats must exit on consecutive cycles.
    pop_cyc16.delete();
    for (int i = 0; i < 8; i++) send_vec(tbl[i]);
    idle();
    drain(1'b0);
    chk("b2b_count", pop_cyc16.size(), 8);
    consec = 0;
    for (int i = 1; i < pop_cyc16.size(); i++)
      if (pop_cyc16[i] - pop_cyc16[i-1] == 1) consec++;
    chk("b2b_consecutive", consec, 7);

    // Backpressure with a full pipeline for three cycles.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_vec(tbl[i]);
      end
      begin
        n = 0;
        while (!out_valid16 && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_first_out", out_valid16, 1);
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        @(negedge clk);
        hs = sum16; hco = c_out16; hov = ovf16;
        chk("stall_in_ready_c0", in_ready16, 0);
        chk("stall_out_valid_c0", out_valid16, 1);
        for (int c = 1; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready16, 0);
          chk("stall_sum_stable", sum16, hs);
          chk("stall_c_out_stable", c_out16, hco);
          chk("stall_ovf_stable", ovf16, hov);
        end
        @(posedge clk); #1;
        out_ready16 = 1'b1;
      end
    join
    idle();
    drain(1'b0);
    chk_lat = 1'b1;

    // Reset with two beats in flight discards both.
    send_vec(tbl[0]);
    send_vec(tbl[1]);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid16 = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid16, 0);
    q16.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid16) saw = 1'b1;
    end
    chk("no_stale_after_rst", saw, 0);
    send_vec(tbl[2]);
    idle();
    drain(1'b0);

    // Exhaustive 4-bit add with both carry-ins, then the subtract sweep.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          for (int ci = 0; ci < 2; ci++) begin
            if (s == 0 || ci == (x & 1)) begin
              r = ref4(x[3:0], y[3:0], ci[0], s[0]);
              send(1'b1, {12'h0, x[3:0]}, {12'h0, y[3:0]}, ci[0], s[0],
                   {12'h0, r[3:0]}, r[4], r[5]);
            end
          end
        end
      end
    end
    idle();
    drain(1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
